// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared types and constants for the data memory responder
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned MEM_WORD_W        = 32;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int unsigned CNT_W             = 4;

endpackage

// File: rtl/data_mem_responder_wait_counter.sv
// rtl/data_mem_responder_wait_counter.sv - loadable down-counter timing the access latency
module mem_wait_counter
  import data_mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory answering one load/store after LATENCY cycles
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned WORD_COUNT = 64,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        mem_busy
);

  localparam int unsigned IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

  state_t state;
  state_t state_next;

  logic                  we_q;
  logic [31:0]           addr_q;
  logic [MEM_WORD_W-1:0] wdata_q;
  logic [MEM_WORD_W-1:0] rdata_q;
  logic                  err_q;

  logic [31:0]      word_off;
  logic             addr_err;
  logic [IDX_W-1:0] idx;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic enter_resp;
  logic commit;

  logic [MEM_WORD_W-1:0] mem_array [0:WORD_COUNT-1];

  // Address decode runs on the latched request so later input wiggles cannot matter.
  assign word_off = (addr_q - BASE_ADDR) >> 2;
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) || (word_off >= WORD_COUNT);
  assign idx      = word_off[IDX_W-1:0];

  mem_wait_counter u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (CNT_W'(LATENCY - 1)),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (mem_req) state_next = ST_WAIT;
      ST_WAIT: if (cnt_zero) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_load   = (state == ST_IDLE) && mem_req;
    cnt_dec    = (state == ST_WAIT);
    enter_resp = (state == ST_WAIT) && cnt_zero;
    commit     = (state == ST_RESP) && we_q && !addr_err && !rst;
    mem_ready  = (state == ST_RESP);
    mem_busy   = (state != ST_IDLE) || mem_req;
    mem_err    = err_q;
    mem_rdata  = rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (cnt_load) begin
      we_q    <= mem_we;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // Response registers hold non-zero values only during the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q   <= enter_resp && addr_err;
      rdata_q <= (enter_resp && !we_q && !addr_err) ? mem_array[idx] : '0;
    end
  end

  // Contents survive reset; only an in-flight store is dropped.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_array[idx] <= wdata_q;
    end
  end

endmodule
